// File: rtl/wptr_full_ctrl_pkg.sv
// Shared Gray-pointer FIFO helpers, used by both the write-side full and read-side empty controllers.
package wptr_full_ctrl_pkg;

  localparam int ADDRSIZE_MAX = 12;
  localparam int PTR_W_MAX    = ADDRSIZE_MAX + 1;
  localparam int DEF_ADDRSIZE = 4;
  localparam int DEPTH        = 2 ** DEF_ADDRSIZE;

  // Callers zero-extend narrower pointers; leading zeros convert to leading zeros both ways.
  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full/almost-full, occupancy and sticky overflow for the dual-clock Gray FIFO.
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 2 ** ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                woverflow_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wdepth,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wdepth_q, wdepth_d;
  logic          wfull_q, wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          woverflow_q, woverflow_d;
  logic [PW-1:0] rbin, full_cmp;

  assign wclken = winc & ~wfull_q;

  always_comb begin
    wbin_d   = wbin_q + PW'(wclken);
    wptr_d   = PW'(bin2gray(PTR_W_MAX'(wbin_d)));
    // Full when the next write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wfull_d  = (wptr_d == full_cmp);
    rbin     = PW'(gray2bin(PTR_W_MAX'(wq2_rptr)));
    // Occupancy uses the pre-increment pointer, so it trails wbin by one edge.
    wdepth_d       = wbin_q - rbin;
    walmost_full_d = (wdepth_d >= PW'(AFULL_THRESH));
    woverflow_d    = woverflow_q;
    if (woverflow_clr)   woverflow_d = 1'b0;
    if (winc && wfull_q) woverflow_d = 1'b1;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wdepth_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wdepth_q       <= wdepth_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wdepth       = wdepth_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at ADDRSIZE=4, AFULL_THRESH=14.
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst, winc, woverflow_clr;
  logic [4:0] wq2_rptr;
  logic [3:0] waddr;
  logic       wclken, wfull, walmost_full, woverflow;
  logic [4:0] wptr, wdepth;

  int nvec = 0;
  int nmiss = 0;

  always #5 wclk = ~wclk;

  wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_THRESH(14)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
    .woverflow_clr(woverflow_clr), .waddr(waddr), .wclken(wclken),
    .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wdepth(wdepth), .woverflow(woverflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wptr"},  32'(wptr), 0);
    chk({tag, ".waddr"}, 32'(waddr), 0);
    chk({tag, ".wfull"}, 32'(wfull), 0);
    chk({tag, ".afull"}, 32'(walmost_full), 0);
    chk({tag, ".wdepth"}, 32'(wdepth), 0);
    chk({tag, ".ovf"},   32'(woverflow), 0);
  endtask

  initial begin
    int rb;
    wrst = 1'b1; winc = 1'b1; woverflow_clr = 1'b0; wq2_rptr = '0;

    // 1. Reset wins over winc
    repeat (3) tick();
    chk_all_zero("rst");

    // 2. Fill 16 from empty
    wrst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("fill.wfull", 32'(wfull), (i == 16) ? 1 : 0);
      if (i == 14) chk("fill.afull14", 32'(walmost_full), 0);
      if (i == 15) chk("fill.afull15", 32'(walmost_full), 1);
    end
    chk("fill.wptr",   32'(wptr), 32'h18);
    chk("fill.waddr",  32'(waddr), 0);
    chk("fill.wdepth", 32'(wdepth), 15);
    winc = 1'b0;
    tick();
    chk("fill.wdepth16", 32'(wdepth), 16);
    chk("fill.full_hold", 32'(wfull), 1);
    chk("fill.afull", 32'(walmost_full), 1);

    // 3. Overflow while full
    winc = 1'b1;
    #1;
    chk("ovf.wclken", 32'(wclken), 0);
    tick();
    chk("ovf.wptr", 32'(wptr), 32'h18);
    chk("ovf.set",  32'(woverflow), 1);
    winc = 1'b0;
    repeat (10) tick();
    chk("ovf.sticky", 32'(woverflow), 1);
    woverflow_clr = 1'b1;
    tick();
    chk("ovf.clr", 32'(woverflow), 0);
    winc = 1'b1;
    tick();
    chk("ovf.set_wins", 32'(woverflow), 1);
    winc = 1'b0; woverflow_clr = 1'b0;

    // 4. Read pointer advances to bin 4 (Gray 00110)
    wq2_rptr = 5'b00110;
    tick();
    chk("drain.wfull",  32'(wfull), 0);
    chk("drain.wdepth", 32'(wdepth), 12);
    chk("drain.afull",  32'(walmost_full), 0);

    // 5. Threshold edge from empty
    wrst = 1'b1; wq2_rptr = '0;
    tick();
    chk_all_zero("rst2");
    wrst = 1'b0; winc = 1'b1;
    repeat (13) tick();
    winc = 1'b0;
    tick();
    chk("thr.wdepth13", 32'(wdepth), 13);
    chk("thr.afull13",  32'(walmost_full), 0);
    winc = 1'b1;
    tick();
    chk("thr.waddr14",  32'(waddr), 14);
    chk("thr.afull_lag", 32'(walmost_full), 0);
    winc = 1'b0;
    tick();
    chk("thr.wdepth14", 32'(wdepth), 14);
    chk("thr.afull14",  32'(walmost_full), 1);

    // 6. Wrap with read pointer trailing two writes behind
    wrst = 1'b1;
    tick();
    wrst = 1'b0; winc = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      rb = (k >= 3) ? k - 3 : 0;
      wq2_rptr = gray5(rb);
      tick();
      chk("wrap.wptr",   32'(wptr), 32'(gray5(k)));
      chk("wrap.waddr",  32'(waddr), 32'(k % 16));
      chk("wrap.wfull",  32'(wfull), 0);
      chk("wrap.wdepth", 32'(wdepth), 32'(((k - 1) - rb) & 31));
      if (k == 16 || k == 32) chk("wrap.msb", 32'(wptr[4]), (k == 16) ? 1 : 0);
    end
    wrst = 1'b1;
    tick();
    chk_all_zero("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
